calc_ctrl: RTL

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/calc_ctrl.sv
// calc_ctrl: operand-entry and ALU handshake FSM for a switch/button calculator.
module calc_ctrl #(
    parameter int W       = 10,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   sw,
    input  logic [1:0]     op_sel,
    input  logic           btn_enter,
    input  logic           btn_clear,
    output logic           alu_start,
    output logic [1:0]     alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic           alu_done,
    input  logic [2*W-1:0] alu_result,
    input  logic           alu_err,
    output logic [2*W-1:0] result,
    output logic           result_valid,
    output logic           error,
    output logic [2:0]     state_led
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_B = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic div_zero;
    assign div_zero     = (op_sel == 2'b11) && (sw == '0);
    assign alu_start    = (state == ISSUE);
    assign result_valid = (state == DONE);
    assign error        = (state == ERR);
    assign state_led    = state;
    always_comb begin
        nxt = state;
        if (btn_clear)
            nxt = IDLE;
        else
            case (state)
                IDLE:    nxt = btn_enter ? GET_B : IDLE;
                GET_B:   nxt = btn_enter ? (div_zero ? ERR : ISSUE) : GET_B;
                ISSUE:   nxt = WAIT;
                // a completion on the final counted cycle beats the timeout
                WAIT:    nxt = alu_done ? (alu_err ? ERR : DONE) : (cnt == TMO ? ERR : WAIT);
                DONE:    nxt = btn_enter ? GET_B : DONE;
                ERR:     nxt = ERR;
                default: nxt = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            result <= '0;
        end else begin
            state <= nxt;
            cnt   <= (state == WAIT && !btn_clear) ? cnt + 1'b1 : '0;
            if (!btn_clear && btn_enter && (state == IDLE || state == DONE))
                alu_a <= sw;
            if (!btn_clear && btn_enter && state == GET_B) begin
                alu_b  <= sw;
                alu_op <= op_sel;
            end
            if (btn_clear)
                result <= '0;
            else if (state == WAIT && alu_done && !alu_err)
                result <= alu_result;
        end
    end
endmodule
